hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Scoreboard-based hazard scheduler for the ID stage. Tracks in-flight writes to the 16
//  architectural registers and, with SR_HAZARD_EN, to the status flags. Drives the ID
//  stage's hazard input so that an instruction issues only when its sources are safe.
//  Sits beside the ID stage. Sets entries on issue from ID and clears them on writeback.
// PARAMETERS
//  MAX_INFLIGHT  3  max outstanding writes per register (pipeline depth ID->WB)
//  CNT_W         2  per-register counter width; must hold MAX_INFLIGHT
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous active-high reset
//  id_valid      in   1   ID holds a real instruction (0 = bubble/flushed)
//  id_src_1      in   4   Rn
//  id_src_2      in   4   Rm, or Rd for stores
//  id_two_src    in   1   id_src_2 is read
//  id_dest       in   4   destination register
//  id_wb_en      in   1   instruction writes id_dest (post condition check)
//  id_s          in   1   instruction updates flags
//  id_cond_used  in   1   cond field != AL (instruction reads flags)
//  wb_wb_en      in   1   WB stage writes register wb_dest this cycle
//  wb_dest       in   4   WB destination
//  sr_update     in   1   status register written this cycle (EXE)
//  hazard        out  1   stall ID / freeze IF (combinational)
//  issue         out  1   id_valid & ~hazard (combinational)
//  busy_map      out  16  bit r = cnt[r] != 0 (registered state)
//  sb_error      out  1   sticky: retire with cnt 0 or count overflow
// BEHAVIOUR
//  - State: cnt[0..15] (CNT_W bits each), flag_cnt (CNT_W), sb_error. Reset clears all; outputs 0.
//  - Retire-release: reg file writes before reads in the same cycle, so src r is "pending" iff
//    cnt[r] - (wb_wb_en & wb_dest==r) != 0.
//  - hazard = id_valid & ( pending(src_1) | (id_two_src & pending(src_2))
//             | (id_wb_en & cnt[id_dest]==MAX_INFLIGHT & ~(wb_wb_en & wb_dest==id_dest)) ).
//  - Saturation stall keeps counters bounded; WAW with room left does not stall (in-order retire).
//  - Per cycle, for each r: inc = issue & id_wb_en & id_dest==r; dec = wb_wb_en & wb_dest==r.
//    inc&dec: unchanged; inc only: +1; dec only: -1. Single-cycle update, no FSM beyond counters.
//  - dec with cnt[r]==0: counter stays 0, sb_error<=1 (sticky until rst).
//  - An issued instruction always retires: a branch flushes only IF/ID, never counted entries.
//  - rst mid-operation: all counters 0 at the next edge regardless of inc/dec that cycle.
//  - hazard never depends on hazard (no loop): its terms use state and ID/WB inputs only.
// CONFIGURATION
//  SR_HAZARD_EN defined: flag_cnt +1 on issue&id_s, -1 on sr_update (same rules as cnt).
//    hazard additionally asserted when id_valid & id_cond_used & (flag_cnt - sr_update) != 0,
//    or id_s & flag_cnt==MAX_INFLIGHT & ~sr_update.
//  Not defined: flag_cnt absent; id_s, id_cond_used, sr_update ignored; flags never stall.
// STRUCTURE
//  Shared package: NUM_REGS=16, REG_W=4, MAX_INFLIGHT default, reg index typedef.
//  One sub-module: sb_counter (CNT_W up/down counter with inc, dec, zero, full, underflow).
//  16 instances plus one for flags under SR_HAZARD_EN; hazard/issue logic in the top.
// TESTING
//  1. rst, then issue ADD r1 (wb_en) -> busy_map=0x0002 next cycle; hazard=0 on that issue.
//  2. r1 pending, ID reads src_1=r1 -> hazard=1 until wb_wb_en&wb_dest=1 cycle, hazard=0 that cycle.
//  3. Store id_two_src=1, src_2=r3 (Rd), cnt[3]=1 -> hazard=1; id_two_src=0 same regs -> hazard=0.
//  4. Issue r2 and retire r2 in same cycle with cnt[2]=1 -> cnt[2] stays 1, busy_map bit2=1.
//  5. Three issues to r4 (no retire) -> 4th with dest r4 stalls; retire r4 same cycle -> issues.
//  6. wb_wb_en with wb_dest=r7, cnt 0 -> sb_error=1, persists; rst -> sb_error=0, busy_map=0.
//  7. SR_HAZARD_EN: CMP (id_s) then ADDEQ -> hazard=1 until sr_update cycle; without macro -> 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg
//   Shared constants and types for the ID-stage hazard scoreboard.
//   NUM_REGS / REG_W describe the architectural register file; the
//   *_DEF values are the default scoreboard depth and counter width.
package hazard_scoreboard_pkg;

  localparam int NUM_REGS         = 16;
  localparam int REG_W            = 4;
  localparam int MAX_INFLIGHT_DEF = 3;
  localparam int CNT_W_DEF        = 2;

  typedef logic [REG_W-1:0] reg_idx_t;

endpackage : hazard_scoreboard_pkg

// File: rtl/hazard_scoreboard_sb_counter.sv
// sb_counter
//   Saturating up/down counter tracking outstanding writes to one resource.
//   inc and dec in the same cycle cancel. A dec at zero leaves the count at
//   zero and pulses underflow; an inc (without dec) at MAX_VAL leaves the
//   count unchanged and pulses overflow. Both pulses are combinational.
// Ports
//   clk, rst   clock, synchronous active-high reset
//   inc, dec   one outstanding write added / retired this cycle
//   cnt        current count (registered)
//   zero, full cnt == 0, cnt == MAX_VAL
//   underflow  dec while zero
//   overflow   inc without dec while full
module sb_counter #(
  parameter int CNT_W   = 2,
  parameter int MAX_VAL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             full,
  output logic             underflow,
  output logic             overflow
);

  assign zero      = (cnt == '0);
  assign full      = (cnt == CNT_W'(MAX_VAL));
  assign underflow = dec & zero;
  assign overflow  = inc & ~dec & full;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule : sb_counter

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Scoreboard hazard scheduler beside the ID stage. One counter per
//   architectural register records in-flight writes (set on issue, cleared
//   on writeback). ID is stalled while a source is still pending or while
//   the destination counter is saturated.
//   Optional feature macro: SR_HAZARD_EN -- also tracks in-flight status
//   flag writes and stalls flag-reading (conditional) instructions.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   id_valid        ID holds a real instruction
//   id_src_1/2      source registers (src_2 read only when id_two_src)
//   id_dest,id_wb_en destination register and its write enable
//   id_s            instruction writes flags
//   id_cond_used    instruction reads flags
//   wb_wb_en,wb_dest register written back this cycle
//   sr_update       status register written this cycle
//   hazard, issue   stall request / instruction leaves ID (combinational)
//   busy_map        per-register "counter nonzero" (from state)
//   sb_error        sticky underflow/overflow indication
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_src_1,
  input  logic [REG_W-1:0]    id_src_2,
  input  logic                id_two_src,
  input  logic [REG_W-1:0]    id_dest,
  input  logic                id_wb_en,
  input  logic                id_s,
  input  logic                id_cond_used,
  input  logic                wb_wb_en,
  input  logic [REG_W-1:0]    wb_dest,
  input  logic                sr_update,
  output logic                hazard,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_map,
  output logic                sb_error
);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] zero;
  logic [NUM_REGS-1:0] full;
  logic [NUM_REGS-1:0] underflow;
  logic [NUM_REGS-1:0] overflow;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] pend_vec;
  logic                reg_haz;
  logic                waw_full;
  logic                flag_haz;
  logic                flag_err;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign inc_vec[r] = issue & id_wb_en & (id_dest == reg_idx_t'(r));
    assign dec_vec[r] = wb_wb_en & (wb_dest == reg_idx_t'(r));

    sb_counter #(
      .CNT_W   (CNT_W),
      .MAX_VAL (MAX_INFLIGHT)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_vec[r]),
      .dec       (dec_vec[r]),
      .cnt       (cnt[r]),
      .zero      (zero[r]),
      .full      (full[r]),
      .underflow (underflow[r]),
      .overflow  (overflow[r])
    );

    // The register file writes before it reads, so the last outstanding
    // write retiring this cycle already makes the value visible to ID.
    assign pend_vec[r] = ~zero[r] & ~(dec_vec[r] & (cnt[r] == CNT_W'(1)));
  end

  // Retire order is in-order, so a WAW with room in the counter is safe;
  // only a saturated counter stalls, unless a retire frees a slot now.
  assign waw_full = id_wb_en & full[id_dest] & ~dec_vec[id_dest];
  assign reg_haz  = pend_vec[id_src_1] | (id_two_src & pend_vec[id_src_2]) | waw_full;

`ifdef SR_HAZARD_EN
  logic [CNT_W-1:0] flag_cnt;
  logic             flag_zero;
  logic             flag_full;
  logic             flag_under;
  logic             flag_over;
  logic             flag_pend;

  sb_counter #(
    .CNT_W   (CNT_W),
    .MAX_VAL (MAX_INFLIGHT)
  ) u_flag_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (issue & id_s),
    .dec       (sr_update),
    .cnt       (flag_cnt),
    .zero      (flag_zero),
    .full      (flag_full),
    .underflow (flag_under),
    .overflow  (flag_over)
  );

  assign flag_pend = ~flag_zero & ~(sr_update & (flag_cnt == CNT_W'(1)));
  assign flag_haz  = (id_cond_used & flag_pend) | (id_s & flag_full & ~sr_update);
  assign flag_err  = flag_under | flag_over;
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{id_s, id_cond_used, sr_update};
  assign flag_haz = 1'b0;
  assign flag_err = 1'b0;
`endif

  // All hazard terms come from state and ID/WB inputs; issue feeds only
  // the counter increments, so there is no combinational loop.
  assign hazard   = id_valid & (reg_haz | flag_haz);
  assign issue    = id_valid & ~hazard;
  assign busy_map = ~zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_error <= 1'b0;
    end else if ((|underflow) || (|overflow) || flag_err) begin
      sb_error <= 1'b1;
    end
  end

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_src_1;
  logic [3:0]  id_src_2;
  logic        id_two_src;
  logic [3:0]  id_dest;
  logic        id_wb_en;
  logic        id_s;
  logic        id_cond_used;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic        sr_update;
  logic        hazard;
  logic        issue;
  logic [15:0] busy_map;
  logic        sb_error;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src_1     (id_src_1),
    .id_src_2     (id_src_2),
    .id_two_src   (id_two_src),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_s         (id_s),
    .id_cond_used (id_cond_used),
    .wb_wb_en     (wb_wb_en),
    .wb_dest      (wb_dest),
    .sr_update    (sr_update),
    .hazard       (hazard),
    .issue        (issue),
    .busy_map     (busy_map),
    .sb_error     (sb_error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: number of in-flight writes per register / flags.
  int m_cnt [16];
  int m_f;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic bit wb_hits(input int r);
    return wb_wb_en && (int'(wb_dest) == r);
  endfunction

  // Outstanding writes still invisible to ID after this cycle's writeback.
  function automatic bit reg_pending(input int r);
    return (m_cnt[r] - int'(wb_hits(r))) > 0;
  endfunction

  function automatic bit model_hazard();
    bit h;
    if (!id_valid) return 1'b0;
    h = reg_pending(int'(id_src_1))
      || (id_two_src && reg_pending(int'(id_src_2)))
      || (id_wb_en && m_cnt[int'(id_dest)] == 3 && !wb_hits(int'(id_dest)));
`ifdef SR_HAZARD_EN
    h = h || (id_cond_used && (m_f - int'(sr_update)) > 0)
          || (id_s && m_f == 3 && !sr_update);
`endif
    return h;
  endfunction

  task automatic model_clear();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_f   = 0;
    m_err = 1'b0;
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    for (int r = 0; r < 16; r++) b[r] = (m_cnt[r] > 0);
    return b;
  endfunction

  task automatic idle();
    id_valid = 0; id_src_1 = 0; id_src_2 = 0; id_two_src = 0;
    id_dest = 0; id_wb_en = 0; id_s = 0; id_cond_used = 0;
    wb_wb_en = 0; wb_dest = 0; sr_update = 0;
  endtask

  // Called at a negedge with inputs applied: check outputs, advance model
  // across the next posedge, return at the following negedge.
  task automatic step();
    bit eh, ei;
    int inc, dec, nxt;
    #1;
    eh = model_hazard();
    ei = id_valid && !eh;
    check("hazard", {31'd0, hazard}, {31'd0, eh});
    check("issue", {31'd0, issue}, {31'd0, ei});
    check("busy_map", {16'd0, busy_map}, {16'd0, model_busy()});
    check("sb_error", {31'd0, sb_error}, {31'd0, m_err});
    if (rst) begin
      model_clear();
    end else begin
      for (int r = 0; r < 16; r++) begin
        inc = (ei && id_wb_en && int'(id_dest) == r) ? 1 : 0;
        dec = wb_hits(r) ? 1 : 0;
        if (dec == 1 && m_cnt[r] == 0) m_err = 1'b1;
        else begin
          nxt = m_cnt[r] + inc - dec;
          if (nxt > 3) m_err = 1'b1;
          else m_cnt[r] = nxt;
        end
      end
`ifdef SR_HAZARD_EN
      inc = (ei && id_s) ? 1 : 0;
      dec = sr_update ? 1 : 0;
      if (dec == 1 && m_f == 0) m_err = 1'b1;
      else begin
        nxt = m_f + inc - dec;
        if (nxt > 3) m_err = 1'b1;
        else m_f = nxt;
      end
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic now_hazard(input string tag, input bit exp);
    #1;
    check(tag, {31'd0, hazard}, {31'd0, exp});
  endtask

  task automatic issue_write(input int d);
    idle(); id_valid = 1; id_dest = 4'(d); id_wb_en = 1;
  endtask

  initial begin
    int busy_regs [$];
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
    #1;
    check("rst_busy", {16'd0, busy_map}, 32'd0);
    check("rst_err", {31'd0, sb_error}, 32'd0);

    // 1: ADD r1
    issue_write(1);
    now_hazard("t1_no_stall", 1'b0);
    step();
    check("t1_busy", {16'd0, busy_map}, 32'h0002);

    // 2: reader of r1 stalls until r1 writes back
    idle(); id_valid = 1; id_src_1 = 1;
    now_hazard("t2_stall", 1'b1);
    step();
    now_hazard("t2_stall2", 1'b1);
    wb_wb_en = 1; wb_dest = 1;
    now_hazard("t2_release", 1'b0);
    step();

    // 3: store reads Rd through src_2
    issue_write(3);
    step();
    idle(); id_valid = 1; id_src_2 = 3; id_two_src = 1;
    now_hazard("t3_two_src", 1'b1);
    step();
    id_two_src = 0;
    now_hazard("t3_one_src", 1'b0);
    step();
    idle(); wb_wb_en = 1; wb_dest = 3;
    step();

    // 4: simultaneous issue and retire of r2
    issue_write(2);
    step();
    issue_write(2); wb_wb_en = 1; wb_dest = 2;
    step();
    check("t4_busy", {16'd0, busy_map}, 32'h0004);
    idle(); wb_wb_en = 1; wb_dest = 2;
    step();

    // 5: saturation on r4
    repeat (3) begin issue_write(4); step(); end
    issue_write(4);
    now_hazard("t5_full", 1'b1);
    step();
    wb_wb_en = 1; wb_dest = 4;
    now_hazard("t5_free", 1'b0);
    check("t5_issue", {31'd0, issue}, 32'd1);
    step();
    idle(); wb_wb_en = 1; wb_dest = 4;
    repeat (3) step();
    idle();
    step();
    check("t5_empty", {16'd0, busy_map}, 32'd0);

    // 6: retire of idle r7, sticky, cleared by rst alongside live counters
    idle(); wb_wb_en = 1; wb_dest = 7;
    step();
    check("t6_err", {31'd0, sb_error}, 32'd1);
    issue_write(9);
    step();
    check("t6_err_sticky", {31'd0, sb_error}, 32'd1);
    issue_write(10); rst = 1;
    step();
    rst = 0; idle();
    #1;
    check("t6_rst_err", {31'd0, sb_error}, 32'd0);
    check("t6_rst_busy", {16'd0, busy_map}, 32'd0);

    // 7: CMP then ADDEQ
    idle(); id_valid = 1; id_s = 1;
    step();
    idle(); id_valid = 1; id_cond_used = 1;
`ifdef SR_HAZARD_EN
    now_hazard("t7_flag_stall", 1'b1);
    step();
    sr_update = 1;
    now_hazard("t7_flag_release", 1'b0);
    step();
`else
    now_hazard("t7_flag_ignored", 1'b0);
    step();
    idle(); sr_update = 1; id_valid = 1; id_cond_used = 1;
    step();
`endif

    // Randomized traffic, writebacks mostly aimed at busy registers.
    rst = 1; idle(); step(); rst = 0;
    for (int i = 0; i < 600; i++) begin
      busy_regs.delete();
      for (int r = 0; r < 16; r++) if (m_cnt[r] > 0) busy_regs.push_back(r);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_src_1     = 4'($urandom_range(0, 15));
      id_src_2     = 4'($urandom_range(0, 15));
      id_two_src   = 1'($urandom_range(0, 1));
      id_dest      = 4'($urandom_range(0, 5));
      id_wb_en     = ($urandom_range(0, 3) != 0);
      id_s         = 1'($urandom_range(0, 1));
      id_cond_used = 1'($urandom_range(0, 1));
      wb_wb_en     = 1'($urandom_range(0, 1));
      if (busy_regs.size() > 0 && $urandom_range(0, 19) != 0)
        wb_dest = 4'(busy_regs[$urandom_range(0, busy_regs.size() - 1)]);
      else
        wb_dest = 4'($urandom_range(0, 15));
      sr_update    = (m_f > 0 || $urandom_range(0, 19) == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      rst          = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 0; idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_hazard_scoreboard
